mem_stage: RTL
==============

Name: mem_stage

Overview:
- Downstream consumer of the execute-stage outputs (e_* bundle) in the Y86-64 pipeline.
- Contains the M pipeline register and the internal data memory.
- Performs the 8-byte loads and stores for rmmovq, mrmovq, call, ret, pushq and popq.
- Produces m_stat and m_valM, and forwards M-register values to writeback and the forwarding logic.

Parameters:
- MEM_BYTES, 1024, size of the byte-addressed data memory.
- ADDR_W, 64, address width; addresses are M_valE or M_valA.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- e_stat  in  4  one-hot status from execute: AOK=0001, HLT=0010, ADR=0100, INS=1000
- e_icode  in  4  instruction code from execute
- e_cnd  in  1  condition flag from execute
- e_valE  in  64  ALU result
- e_valA  in  64  pass-through valA
- e_dstE  in  4  destination register for valE (15 = none)
- e_dstM  in  4  destination register for valM (15 = none)
- M_stall  in  1  hold the M register
- M_bubble  in  1  load a nop bubble into the M register
- W_stat  in  4  status currently in writeback; used for store suppression
- M_stat, M_icode, M_dstE, M_dstM  out  4 each  registered M stage
- M_cnd  out  1  registered
- M_valE, M_valA  out  64 each  registered
- m_stat  out  4  effective status after the memory access
- m_valM  out  64  load data
- dmem_error  out  1  address fault this cycle

Behaviour:
- Reset (rst_n low, async) loads the M register with the bubble values:
  - M_stat=0001, M_icode=1 (nop), M_cnd=0, M_valE=0, M_valA=0, M_dstE=15, M_dstM=15.
  - Memory contents are not reset.
  - Reset mid-access discards the access; no partial store occurs.
- M register update, each rising clk edge:
  - M_stall=1: hold all fields. M_stall has priority over M_bubble.
  - else M_bubble=1: load the bubble values.
  - else capture e_*.
- Address selection (combinational):
  - icode 4, 5, 8, 10: address = M_valE.
  - icode 9, 11: address = M_valA.
  - Any other icode: no access, m_valM=0.
- Reads: icode 5, 9, 11.
  - Combinational, same cycle.
  - m_valM = mem[addr+7..addr], little-endian; byte at addr is bits [7:0].
- Writes: icode 4, 8, 10.
  - Write data = M_valA, 8 bytes, little-endian.
  - Committed on the rising clk edge only when all of the following hold: M_stall=0, dmem_error=0, M_stat=0001, W_stat=0001.
  - Exactly one commit per instruction.
- Bounds:
  - dmem_error=1 when an access is selected and addr > MEM_BYTES-8, evaluated on the full 64-bit value.
  - This includes wrap-around: addr+7 overflowing 64 bits counts as an error.
  - On error: no store, m_valM=0.
- Status:
  - m_stat = 0100 (ADR) if dmem_error.
  - Otherwise m_stat = M_stat.
  - An incoming non-AOK M_stat passes through unchanged.
- Read-after-write:
  - A load in the cycle after a store to the same address returns the new data.
  - A load in the same cycle as a store can only occur in the same instruction, which cannot happen.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - A selected access with addr[2:0] != 0 also raises dmem_error.
  - That access is treated as ADR: no store, m_valM=0.
- Undefined:
  - Unaligned accesses are legal, with byte-granular little-endian assembly.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs immediately M_icode=1, M_dstE=15, M_dstM=15, M_stat=0001, m_stat=0001.
- Store/load round trip:
  - Stimulus: rmmovq with e_valE=0x40, e_valA=0x1122334455667788, then mrmovq with e_valE=0x40.
  - Required: m_valM=0x1122334455667788 and mem[0x40]=0x88.
- Push/pop: pushq with e_valE=0x3F8, e_valA=0xABCD, then popq with e_valA=0x3F8 -> m_valM=0xABCD.
- Bounds:
  - mrmovq with e_valE=MEM_BYTES-7 -> dmem_error=1, m_stat=0100, m_valM=0.
  - e_valE=0xFFFFFFFFFFFFFFFC -> same error response.
- Store suppression:
  - rmmovq to 0x80 with W_stat=0010 -> memory at 0x80 unchanged.
  - Same store with M_stall=1 for 3 cycles, then released -> a single commit, data correct.
- Stall/bubble priority:
  - M_stall=1 and M_bubble=1 together -> register held.
  - M_bubble=1 alone -> M_icode=1, M_dstE=15 next cycle.
  - With DMEM_ALIGN_CHECK_EN defined, access to 0x41 -> m_stat=0100.

Source files
------------

// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed data memory and status/bounds logic.
// Optional build macro DMEM_ALIGN_CHECK_EN: treat accesses not aligned to 8 bytes as address faults.
module mem_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [3:0]  W_stat,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic        dmem_error
);

  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_ADR = 4'b0100;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] REG_NONE = 4'd15;
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);

  logic [3:0]  r_stat, r_icode, r_dstE, r_dstM;
  logic        r_cnd;
  logic [63:0] r_valE, r_valA;
  logic [7:0]  r_mem [MEM_BYTES];

  logic              w_sel_e, w_sel_a, w_acc, w_rd, w_wr, w_err, w_wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_idx;
  logic [63:0]       w_rdata;

  // M pipeline register: stall holds, bubble inserts a nop, otherwise capture execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat  <= STAT_AOK;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= REG_NONE;
      r_dstM  <= REG_NONE;
    end else if (M_stall) begin
      r_stat  <= r_stat;
    end else if (M_bubble) begin
      r_stat  <= STAT_AOK;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= REG_NONE;
      r_dstM  <= REG_NONE;
    end else begin
      r_stat  <= e_stat;
      r_icode <= e_icode;
      r_cnd   <= e_cnd;
      r_valE  <= e_valE;
      r_valA  <= e_valA;
      r_dstE  <= e_dstE;
      r_dstM  <= e_dstM;
    end
  end

  always_comb begin
    w_sel_e = (r_icode == I_RMMOVQ) || (r_icode == I_MRMOVQ) ||
              (r_icode == I_CALL)   || (r_icode == I_PUSHQ);
    w_sel_a = (r_icode == I_RET) || (r_icode == I_POPQ);
    w_acc   = w_sel_e || w_sel_a;
    w_rd    = (r_icode == I_MRMOVQ) || (r_icode == I_RET) || (r_icode == I_POPQ);
    w_wr    = (r_icode == I_RMMOVQ) || (r_icode == I_CALL) || (r_icode == I_PUSHQ);
    w_addr  = w_sel_a ? ADDR_W'(r_valA) : ADDR_W'(r_valE);
    w_idx   = w_addr[IDX_W-1:0];
    // Comparing the base address against the last legal start also catches addr+7 wrapping
`ifdef DMEM_ALIGN_CHECK_EN
    w_err   = w_acc && ((w_addr > ADDR_LIMIT) || (w_addr[2:0] != 3'd0));
`else
    w_err   = w_acc && (w_addr > ADDR_LIMIT);
`endif
    w_wr_en = w_wr && !M_stall && !w_err && (r_stat == STAT_AOK) && (W_stat == STAT_AOK);
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      w_rdata[8*i +: 8] = r_mem[w_idx + IDX_W'(i)];
    end
  end

  // Memory has no reset; an asserted reset also blocks any store at this edge
  always_ff @(posedge clk) begin
    if (w_wr_en && rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_idx + IDX_W'(i)] <= r_valA[8*i +: 8];
      end
    end
  end

  assign M_stat     = r_stat;
  assign M_icode    = r_icode;
  assign M_dstE     = r_dstE;
  assign M_dstM     = r_dstM;
  assign M_cnd      = r_cnd;
  assign M_valE     = r_valE;
  assign M_valA     = r_valA;
  assign dmem_error = w_err;
  assign m_stat     = w_err ? STAT_ADR : r_stat;
  assign m_valM     = (w_rd && !w_err) ? w_rdata : 64'd0;

endmodule
